segre_main_memory: RTL and testbench



---
 rtl/segre_main_memory_if.sv | 24 ++
 rtl/segre_main_memory.sv | 126 ++++++++++++
 tb/tb_segre_main_memory.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/segre_main_memory_if.sv
// Cache-miss/writeback bus between the data cache (master) and main memory (slave).
// Signal suffixes are relative to the memory side.
interface segre_main_memory_if #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_BITS = 128
);
  logic                 rd_i;
  logic                 wr_i;
  logic [WORD_SIZE-1:0] addr_i;
  logic [LINE_BITS-1:0] cache_line_i;
  logic [LINE_BITS-1:0] cache_line_o;
  logic                 mem_ready_o;
  logic                 busy_o;

  modport slave (
    input  rd_i, wr_i, addr_i, cache_line_i,
    output cache_line_o, mem_ready_o, busy_o
  );

  modport master (
    output rd_i, wr_i, addr_i, cache_line_i,
    input  cache_line_o, mem_ready_o, busy_o
  );
endinterface

// File: rtl/segre_main_memory.sv
// Line-granular main memory: serves one fill or writeback at a time after a fixed
// latency, answering with a one-cycle ready pulse followed by a one-cycle guard gap.
module segre_main_memory #(
  parameter int WORD_SIZE             = 32,
  parameter int CACHE_LINE_SIZE_BYTES = 16,
  parameter int MEM_SIZE_LINES        = 1024,
  parameter int LATENCY               = 5
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  segre_main_memory_if.slave    bus
);

  localparam int LINE_BITS = CACHE_LINE_SIZE_BYTES * 8;
  localparam int OFF_W     = $clog2(CACHE_LINE_SIZE_BYTES);
  localparam int IDX_W     = $clog2(MEM_SIZE_LINES);
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_accept;
  logic                 w_done;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_unused_addr;

  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_op_wr;
  logic [LINE_BITS-1:0] r_line;
  logic [LINE_BITS-1:0] r_rdata;
  logic                 r_ready;
  logic                 r_busy;
  logic [LINE_BITS-1:0] r_mem [MEM_SIZE_LINES];

  // Offset and high address bits do not select a line, so addresses wrap modulo memory size.
  assign w_idx         = bus.addr_i[OFF_W +: IDX_W];
  assign w_unused_addr = ^bus.addr_i;
  assign w_done        = (r_state == S_WAIT) && (r_cnt == '0);

  // Next-state decode; a write wins over a simultaneous read.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.wr_i || bus.rd_i) begin
          w_next_state = S_WAIT;
          w_accept     = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_RESP: begin
        w_next_state = S_GAP;
      end
      S_GAP: begin
        // The edge that ends RESP never sees a request; the requester drops its
        // level during GAP, so the edge closing GAP may already start the next one.
        if (bus.wr_i || bus.rd_i) begin
          w_next_state = S_WAIT;
          w_accept     = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, latched transaction, latency counter and registered outputs.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_op_wr <= 1'b0;
      r_line  <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == S_RESP);
      r_busy  <= (w_next_state != S_IDLE);
      if (w_accept) begin
        r_idx   <= w_idx;
        r_op_wr <= bus.wr_i;
        r_line  <= bus.cache_line_i;
        r_cnt   <= CNT_W'(LATENCY - 1);
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done && !r_op_wr) begin
        r_rdata <= r_mem[r_idx];
      end
    end
  end

  // Line array: deliberately not reset; a write commits only as WAIT completes.
  always_ff @(posedge clk_i) begin
    if (w_done && r_op_wr) begin
      r_mem[r_idx] <= r_line;
    end
  end

  assign bus.cache_line_o = r_rdata;
  assign bus.mem_ready_o  = r_ready;
  assign bus.busy_o       = r_busy;

endmodule

// File: tb/tb_segre_main_memory.sv
// Directed bench for segre_main_memory: a LATENCY=5 instance carries most vectors,
// a LATENCY=1 instance covers the minimum-latency corner.
module tb_segre_main_memory;

  localparam logic [127:0] L3   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] LAA  = {16{8'hAA}};
  localparam logic [127:0] L11  = {16{8'h11}};
  localparam logic [127:0] L55  = {16{8'h55}};
  localparam logic [127:0] LDE  = {4{32'hDEADBEEF}};
  localparam logic [127:0] L12  = 128'h123456789ABCDEF00FEDCBA987654321;
  localparam logic [127:0] LCA  = {8{16'hCAFE}};

  logic clk;
  logic rsn;
  int   n_checks;
  int   n_fail;

  segre_main_memory_if #(.WORD_SIZE(32), .LINE_BITS(128)) bus5 ();
  segre_main_memory_if #(.WORD_SIZE(32), .LINE_BITS(128)) bus1 ();

  segre_main_memory #(.WORD_SIZE(32), .CACHE_LINE_SIZE_BYTES(16), .MEM_SIZE_LINES(1024), .LATENCY(5))
    u_dut (.clk_i(clk), .rsn_i(rsn), .bus(bus5));

  segre_main_memory #(.WORD_SIZE(32), .CACHE_LINE_SIZE_BYTES(16), .MEM_SIZE_LINES(1024), .LATENCY(1))
    u_dut_l1 (.clk_i(clk), .rsn_i(rsn), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready5(output logic [127:0] line);
    int n;
    n = 0;
    while (!bus5.mem_ready_o && n < 20) begin
      step();
      n++;
    end
    if (!bus5.mem_ready_o) check("ready_timeout", 128'(0), 128'(1));
    line = bus5.cache_line_o;
  endtask

  task automatic wait_idle5();
    int n;
    n = 0;
    while (bus5.busy_o && n < 20) begin
      step();
      n++;
    end
    if (bus5.busy_o) check("idle_timeout", 128'(1), 128'(0));
  endtask

  task automatic write5(input logic [31:0] a, input logic [127:0] d, output logic [127:0] line_at_rdy);
    bus5.wr_i         = 1'b1;
    bus5.addr_i       = a;
    bus5.cache_line_i = d;
    step();
    bus5.wr_i = 1'b0;
    wait_ready5(line_at_rdy);
    wait_idle5();
  endtask

  task automatic read5(input logic [31:0] a, output logic [127:0] d);
    bus5.rd_i   = 1'b1;
    bus5.addr_i = a;
    step();
    wait_ready5(d);
    bus5.rd_i = 1'b0;
    wait_idle5();
  endtask

  initial begin
    logic [127:0] d;
    int           pulses;
    int           back2back;
    int           misplaced;
    logic         prev;

    n_checks = 0;
    n_fail   = 0;
    bus5.rd_i = 1'b0; bus5.wr_i = 1'b0; bus5.addr_i = 32'h0; bus5.cache_line_i = 128'h0;
    bus1.rd_i = 1'b0; bus1.wr_i = 1'b0; bus1.addr_i = 32'h0; bus1.cache_line_i = 128'h0;
    rsn = 1'b0;
    #1;
    check("rst_ready", 128'(bus5.mem_ready_o), 128'(0));
    check("rst_busy", 128'(bus5.busy_o), 128'(0));
    check("rst_line", bus5.cache_line_o, 128'h0);
    check("rst_l1_busy", 128'(bus1.busy_o), 128'(0));
    #11 rsn = 1'b1;
    step();

    // Preload line 3; a write leaves the read register at its reset value
    write5(32'h30, L3, d);
    check("wr_keeps_line_rst", d, 128'h0);

    // Cycle-exact read of line 3
    bus5.rd_i   = 1'b1;
    bus5.addr_i = 32'h30;
    step();
    check("t1_busy0", 128'(bus5.busy_o), 128'(1));
    check("t1_rdy0", 128'(bus5.mem_ready_o), 128'(0));
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("t1_rdy%0d", k), 128'(bus5.mem_ready_o), 128'(k == 5));
      check($sformatf("t1_busy%0d", k), 128'(bus5.busy_o), 128'(1));
      if (k == 5) begin
        check("t1_data", bus5.cache_line_o, L3);
        bus5.rd_i = 1'b0;
      end
    end
    step();
    check("t1_busy7", 128'(bus5.busy_o), 128'(0));

    // Write with offset bits, read back via the aligned address
    write5(32'h44, LAA, d);
    check("t2_line_during_wr", d, L3);
    read5(32'h40, d);
    check("t2_raw", d, LAA);

    // Simultaneous rd/wr: write wins, read restarts from GAP with rd still held
    write5(32'h80, L11, d);
    bus5.rd_i = 1'b1; bus5.wr_i = 1'b1;
    bus5.addr_i = 32'h80; bus5.cache_line_i = L55;
    step();
    bus5.wr_i = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (bus5.mem_ready_o) pulses++;
    end
    check("t3_one_pulse", 128'(pulses), 128'(1));
    check("t3_no_read", bus5.cache_line_o, LAA);
    step();
    check("t3_restart_busy", 128'(bus5.busy_o), 128'(1));
    wait_ready5(d);
    bus5.rd_i = 1'b0;
    check("t3_rd_data", d, L55);
    wait_idle5();

    // rd held continuously: one pulse every 7 cycles, never back to back
    bus5.rd_i   = 1'b1;
    bus5.addr_i = 32'h40;
    step();
    pulses = 0; back2back = 0; misplaced = 0; prev = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (bus5.mem_ready_o) begin
        pulses++;
        if (prev) back2back++;
        if ((k % 7) != 5) misplaced++;
      end
      prev = bus5.mem_ready_o;
    end
    wait_ready5(d);
    bus5.rd_i = 1'b0;
    wait_idle5();
    check("t4_pulses", 128'(pulses), 128'(3));
    check("t4_back2back", 128'(back2back), 128'(0));
    check("t4_misplaced", 128'(misplaced), 128'(0));
    check("t4_data", d, LAA);

    // Asynchronous reset mid-WAIT aborts an uncommitted write
    bus5.wr_i = 1'b1; bus5.addr_i = 32'h40; bus5.cache_line_i = LDE;
    step();
    bus5.wr_i = 1'b0;
    step();
    step();
    #2 rsn = 1'b0;
    #1;
    check("t5_rst_busy", 128'(bus5.busy_o), 128'(0));
    check("t5_rst_ready", 128'(bus5.mem_ready_o), 128'(0));
    check("t5_rst_line", bus5.cache_line_o, 128'h0);
    #1 rsn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus5.mem_ready_o) pulses++;
    end
    check("t5_no_pulse", 128'(pulses), 128'(0));
    read5(32'h40, d);
    check("t5_old_data", d, LAA);

    // Address wrap: 0x4010 and 0x0010 both map to line 1
    write5(32'h4010, L12, d);
    read5(32'h0010, d);
    check("t6_wrap", d, L12);

    // LATENCY=1 instance
    bus1.wr_i = 1'b1; bus1.addr_i = 32'h20; bus1.cache_line_i = LCA;
    step();
    bus1.wr_i = 1'b0;
    check("l1_wr_busy0", 128'(bus1.busy_o), 128'(1));
    check("l1_wr_rdy0", 128'(bus1.mem_ready_o), 128'(0));
    step();
    check("l1_wr_rdy1", 128'(bus1.mem_ready_o), 128'(1));
    step();
    check("l1_gap_rdy", 128'(bus1.mem_ready_o), 128'(0));
    check("l1_gap_busy", 128'(bus1.busy_o), 128'(1));
    step();
    check("l1_idle", 128'(bus1.busy_o), 128'(0));
    bus1.rd_i = 1'b1; bus1.addr_i = 32'h20;
    step();
    check("l1_rd_rdy0", 128'(bus1.mem_ready_o), 128'(0));
    step();
    check("l1_rd_rdy1", 128'(bus1.mem_ready_o), 128'(1));
    check("l1_rd_data", bus1.cache_line_o, LCA);
    bus1.rd_i = 1'b0;
    step();
    step();
    check("l1_final_idle", 128'(bus1.busy_o), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
